alu_share_ctrl: RTL and testbench
=================================

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 SHALL have parameter MOD_LATENCY, default 40: cycles the ALU needs to run a MOD (opcode 3'b111), range 2..255.
REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each: requester has an operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 each: operation accepted this cycle.
REQ-006 SHALL have ports req0_a/req0_b/req1_a/req1_b, input, 32 each: signed operands.
REQ-007 SHALL have ports req0_op/req1_op, input, 3 each: ALUop code (000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD).
REQ-008 SHALL have port rsp_valid, output, 1: result available.
REQ-009 SHALL have port rsp_ready, input, 1: consumer takes result.
REQ-010 SHALL have port rsp_result, output, 32: captured ALU result.
REQ-011 SHALL have port rsp_id, output, 1: requester index owning rsp_result.
REQ-012 SHALL have ports alu_a/alu_b, output, 32 each; alu_op, output, 3; alu_reset, output, 1: drive the shared alu_32_bit.
REQ-013 SHALL have port alu_result, input, 32: alu_32_bit result.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE, ready SHALL be asserted combinationally to exactly one requester whose valid is high, chosen by round-robin; neither ready when no valid.
REQ-017 When both valids are high in the same cycle, grant SHALL go to the requester not named by last_grant; when only one is valid, it SHALL be granted regardless of last_grant.
REQ-018 On a valid&ready handshake, operands, op and requester index SHALL be latched, last_grant SHALL update to the granted index, and state SHALL go to EXEC.
REQ-019 In EXEC, alu_a/alu_b/alu_op SHALL be driven from latched values, constant for the whole state.
REQ-020 For op != 111, EXEC SHALL last exactly 1 cycle; alu_result SHALL be captured into rsp_result at its end.
REQ-021 For op == 111, alu_reset SHALL be driven 0 for exactly MOD_LATENCY cycles of EXEC via a down-counter, then alu_result captured; alu_reset SHALL be 1 at all other times.
REQ-022 Latency: accept in cycle N; rsp_valid high from cycle N+2 (non-MOD) or N+1+MOD_LATENCY (MOD).
REQ-023 In RESP, rsp_valid SHALL stay high with rsp_result/rsp_id stable until rsp_ready is high; on that edge state SHALL return to IDLE.
REQ-024 No new request SHALL be accepted in EXEC or RESP; held requests SHALL be accepted no earlier than the cycle after rsp handshake.
REQ-025 A requester dropping valid before its ready SHALL lose nothing and alter no state.
REQ-026 When no operation is in progress, alu_a, alu_b and alu_op SHALL be driven 0.

Reset
REQ-027 While reset is low: state IDLE, rsp_valid 0, rsp_result 0, rsp_id 0, req ready 0, busy 0, alu_reset 1, alu_a/alu_b/alu_op 0, counter 0, last_grant 1 (so req0 wins first contention).
REQ-028 Reset asserted mid-EXEC or mid-RESP SHALL abandon the operation silently; no response SHALL be produced for it after release.

Structure
REQ-029 Opcode constants, FSM state encoding and MOD_LATENCY default SHALL live in shared package alu_ctrl_pkg.
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arbiter_2 (inputs valid[1:0], last_grant; output grant[1:0]); alu_32_bit SHALL remain external.

Verification
REQ-031 req0 AND a=0xAAAAAAAA b=0x55555555, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_result=0x00000000, rsp_id=0.
REQ-032 req1 MOD a=32 b=9 -> alu_reset low exactly MOD_LATENCY cycles, rsp_result=5, rsp_id=1, rsp_valid at N+1+MOD_LATENCY.
REQ-033 Both valid from reset, req0 ADD 0x0000FFFF+0xFFFF0000, req1 SUB same operands -> req0 served first (0xFFFFFFFF), then req1 (0x0001FFFF); grant alternates on continued contention.
REQ-034 rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_result/rsp_id stable, both ready low, busy high; handshake then returns IDLE.
REQ-035 reset pulled low at cycle 5 of a MOD -> all outputs to REQ-027 values immediately; after release no rsp_valid until a new request.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: opcodes, FSM encoding and
// the default MOD execution time.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    localparam int MOD_LATENCY_DEFAULT = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: under contention the requester that did not win
// last time is chosen; a lone requester always wins.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant[0] = valid[0] & (~valid[1] | last_grant);
        grant[1] = valid[1] & (~valid[0] | ~last_grant);
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one external alu_32_bit, sequences the
// multi-cycle MOD via alu_reset, and holds the result until it is consumed.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MOD_LATENCY = MOD_LATENCY_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_id,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_reset,
    input  logic [31:0] alu_result,
    output logic        busy
);

    // The counter holds the number of EXEC cycles remaining after the current one.
    localparam logic [7:0] MOD_CNT_INIT = 8'(MOD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        id_q, id_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  grant;

    rr_arbiter_2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Gate with reset so no handshake is advertised while held in reset.
                req0_ready = grant[0] & reset;
                req1_ready = grant[1] & reset;
                if (|grant) begin
                    a_d          = grant[1] ? req1_a  : req0_a;
                    b_d          = grant[1] ? req1_b  : req0_b;
                    op_d         = grant[1] ? req1_op : req0_op;
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    cnt_d        = ((grant[1] ? req1_op : req0_op) == OP_MOD) ? MOD_CNT_INIT : 8'd0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 8'd0) begin
                    result_d = alu_result;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            op_q         <= 3'd0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            result_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        alu_a      = (state_q == ST_EXEC) ? a_q  : 32'd0;
        alu_b      = (state_q == ST_EXEC) ? b_q  : 32'd0;
        alu_op     = (state_q == ST_EXEC) ? op_q : 3'd0;
        alu_reset  = !((state_q == ST_EXEC) && (op_q == OP_MOD));
        busy       = (state_q != ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);
        rsp_result = result_q;
        rsp_id     = id_q;
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural alu_32_bit model that
// only yields a MOD result after MOD_LATENCY cycles of alu_reset low.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int ML = MOD_LATENCY_DEFAULT;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_id;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_reset, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    alu_share_ctrl #(.MOD_LATENCY(ML)) dut (
        .CLK(CLK), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_reset(alu_reset), .alu_result(alu_result), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return (b == 32'd0) ? 32'd0 : 32'($signed(a) % $signed(b));
        endcase
    endfunction

    // External ALU: MOD output is garbage until alu_reset has been low long enough.
    int mod_low = 0;
    always @(negedge CLK) mod_low <= alu_reset ? 0 : mod_low + 1;
    always_comb begin
        alu_result = ref_alu(alu_op, alu_a, alu_b);
        if (alu_op == OP_MOD && mod_low < ML) alu_result = 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    bit   m_busy = 1'b0;
    bit   m_last = 1'b1;
    bit   m_seen = 1'b0;
    int   low_cnt = 0;

    always @(negedge CLK) begin
        logic [1:0] exp_g;
        exp_t       e;
        if (!reset) begin
            sb.delete();
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_seen  = 1'b0;
            low_cnt = 0;
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            if (!m_busy) begin
                chk("alu_idle", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
                chk("alu_reset_idle", {31'd0, alu_reset}, 32'd1);
            end
            exp_g = 2'b00;
            if (!m_busy) begin
                if (req0_valid && req1_valid) exp_g = m_last ? 2'b01 : 2'b10;
                else                          exp_g = {req1_valid, req0_valid};
            end
            chk("grant", {30'd0, req1_ready, req0_ready}, {30'd0, exp_g});
            if (!alu_reset) low_cnt++;

            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    if (!m_seen) begin
                        chk("rsp_latency", cyc, sb[0].due);
                        chk("mod_low_cycles", low_cnt, (sb[0].op == OP_MOD) ? ML : 0);
                        m_seen = 1'b1;
                    end
                    chk("rsp_result", rsp_result, sb[0].res);
                    chk("rsp_id", {31'd0, rsp_id}, {31'd0, sb[0].id});
                    if (rsp_ready) begin
                        $display("txn id=%0d op=%0d result=%h cyc=%0d", sb[0].id, sb[0].op, rsp_result, cyc);
                        void'(sb.pop_front());
                        m_busy = 1'b0;
                        m_seen = 1'b0;
                    end
                end
            end else if (m_busy && sb.size() > 0 && cyc >= sb[0].due) begin
                chk("rsp_missing", cyc, sb[0].due);
                void'(sb.pop_front());
                m_busy = 1'b0;
                m_seen = 1'b0;
            end

            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                e.id  = (req0_valid && req0_ready) ? 1'b0 : 1'b1;
                e.op  = e.id ? req1_op : req0_op;
                e.res = e.id ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
                e.due = cyc + ((e.op == OP_MOD) ? 1 + ML : 2);
                sb.push_back(e);
                m_last  = e.id;
                m_busy  = 1'b1;
                low_cnt = 0;
            end
        end
    end

    task automatic wait_hs(output int who);
        who = -1;
        for (int i = 0; i < 200 && who < 0; i++) begin
            @(negedge CLK);
            if (req0_valid && req0_ready)      who = 0;
            else if (req1_valid && req1_ready) who = 1;
        end
        chk("hs_timeout", (who < 0) ? 32'd1 : 32'd0, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        chk("idle_timeout", {31'd0, !done}, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_reset", {31'd0, alu_reset}, 32'd1);
        chk("rst_alu_ops", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 reset = 1'b0;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2 reset = 1'b1;
    endtask

    task automatic rand_req(output logic v, output logic [31:0] a, output logic [31:0] b, output logic [2:0] op);
        v  = 1'b1;
        op = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
        b  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 50));
        if (op == OP_MOD && b == 32'd0) b = 32'd1;
    endtask

    initial begin
        int  who;
        bit  acc0, acc1;
        bit  seen;

        // Reset state with both requesters pushing
        req0_valid = 1'b1; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_op = OP_SUB;
        repeat (3) @(negedge CLK);
        chk_reset_vals();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge CLK);
        #2 reset = 1'b1;

        // req0 AND, immediate consume
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        req0_a = 32'hAAAAAAAA; req0_b = 32'h55555555; req0_op = OP_AND; req0_valid = 1'b1;
        wait_hs(who);
        req0_valid = 1'b0;
        wait_idle();

        // req1 MOD 32 % 9
        req1_a = 32'd32; req1_b = 32'd9; req1_op = OP_MOD; req1_valid = 1'b1;
        wait_hs(who);
        req1_valid = 1'b0;
        wait_idle();

        // Contention from reset: req0 first, then alternation
        do_reset();
        @(posedge CLK); #1;
        req0_a = 32'h0000FFFF; req0_b = 32'hFFFF0000; req0_op = OP_ADD;
        req1_a = 32'h0000FFFF; req1_b = 32'hFFFF0000; req1_op = OP_SUB;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (4) wait_hs(who);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Back-pressure for 10 cycles with a contender waiting
        rsp_ready = 1'b0;
        req0_a = 32'h12345678; req0_b = 32'h0F0F0F0F; req0_op = OP_XOR; req0_valid = 1'b1;
        req1_a = 32'h80000000; req1_b = 32'h00000001; req1_op = OP_SLT; req1_valid = 1'b1;
        wait_hs(who);
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            seen = rsp_valid;
        end
        chk("bp_rsp_timeout", {31'd0, !seen}, 32'd0);
        repeat (10) @(negedge CLK);
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        wait_hs(who);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a MOD
        req0_a = 32'd1000; req0_b = 32'd7; req0_op = OP_MOD; req0_valid = 1'b1;
        wait_hs(who);
        repeat (4) @(posedge CLK);
        #3 reset = 1'b0;
        #1 chk_reset_vals();
        req0_valid = 1'b0;
        @(posedge CLK);
        #2 reset = 1'b1;
        repeat (60) @(negedge CLK);
        chk("post_rst_quiet", {31'd0, rsp_valid | busy}, 32'd0);
        @(posedge CLK); #1;

        // Randomized traffic with back-pressure and withdrawn requests
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge CLK); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (acc0 || !req0_valid) begin
                if ($urandom_range(0, 9) < 6) rand_req(req0_valid, req0_a, req0_b, req0_op);
                else req0_valid = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                req0_valid = 1'b0;
            end
            if (acc1 || !req1_valid) begin
                if ($urandom_range(0, 9) < 6) rand_req(req1_valid, req1_a, req1_b, req1_op);
                else req1_valid = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
